// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle sequencer:
// FSM states, opcodes, ALU operations and datapath select codes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR, S_FAULT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111,
    ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001
  } alu_op_t;

  localparam logic [1:0] SRC_A_RS1   = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_PC    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // size is funct3[1:0]: 00 byte, 01 half, anything else is treated as a word.
  function automatic logic [3:0] byte_en_f(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off == 2'd3;
      default: return off != 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps opcode/funct3/funct7[5] to the ALU operation; anything that is not
// OP, OP-IMM or BRANCH gets ADD (address and link arithmetic).
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output alu_op_t    alu_op_o
);

  // NOTE: assign a default before any branch so every path drives the output and no latch is inferred.
  always_comb begin
    alu_op_o = ALU_ADD;
    case (opcode_i)
      OP_OP, OP_IMM: begin
        case (funct3_i)
          // Bit 30 is an immediate bit for ADDI, so only R-type may select SUB.
          3'b000: alu_op_o = (opcode_i == OP_OP && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op_o = ALU_SLL;
          3'b010: alu_op_o = ALU_SLT;
          3'b011: alu_op_o = ALU_SLTU;
          3'b100: alu_op_o = ALU_XOR;
          3'b101: alu_op_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110: alu_op_o = ALU_OR;
          default: alu_op_o = ALU_AND;
        endcase
      end
      OP_BRANCH: begin
        case (funct3_i[2:1])
          2'b00:   alu_op_o = ALU_SUB;
          2'b10:   alu_op_o = ALU_SLT;
          2'b11:   alu_op_o = ALU_SLTU;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: one state per datapath step, with a single
// memory port shared by fetch and load/store and a bounded ready wait.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       zero_i,
  input  logic       alu_lsb_i,
  input  logic [1:0] addr_lsb_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic [3:0] byte_en_o,
  output logic       adr_src_o,
  output logic       ir_wr_en_o,
  output logic       pc_wr_en_o,
  output logic       reg_wr_en_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [2:0] imm_src_o,
  output logic [3:0] alu_control_o,
  output logic       retired_o,
  output logic       fault_o
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       off_q, off_d;
  alu_op_t          dec_op;
  logic [2:0]       imm_dec;
  logic             taken;
  logic             expired;

  alu_decoder u_alu_decoder (
    .opcode_i   (opcode_i),
    .funct3_i   (funct3_i),
    .funct7_5_i (funct7_5_i),
    .alu_op_o   (dec_op)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    imm_dec = IMM_I;
    case (opcode_i)
      OP_STORE:         imm_dec = IMM_S;
      OP_BRANCH:        imm_dec = IMM_B;
      OP_JAL:           imm_dec = IMM_J;
      OP_LUI, OP_AUIPC: imm_dec = IMM_U;
      default:          imm_dec = IMM_I;
    endcase
  end

  // Branch sense: funct3[0] inverts the base comparison.
  assign taken   = (funct3_i[2] ? alu_lsb_i : zero_i) ^ funct3_i[0];
  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    off_d         = off_q;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    byte_en_o     = 4'b0000;
    adr_src_o     = 1'b0;
    ir_wr_en_o    = 1'b0;
    pc_wr_en_o    = 1'b0;
    reg_wr_en_o   = 1'b0;
    alu_src_a_o   = SRC_A_RS1;
    alu_src_b_o   = SRC_B_RS2;
    result_src_o  = RES_ALUOUT;
    imm_src_o     = IMM_I;
    alu_control_o = ALU_ADD;
    retired_o     = 1'b0;
    fault_o       = 1'b0;

    case (state_q)
      S_IDLE: if (trigger) state_d = S_FETCH;

      S_FETCH: begin
        mem_req_o    = 1'b1;
        byte_en_o    = 4'b1111;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_FOUR;
        result_src_o = RES_ALU;
        if (mem_ready_i) begin
          ir_wr_en_o = 1'b1;
          pc_wr_en_o = 1'b1;
          state_d    = S_DECODE;
        end else if (expired) state_d = S_FAULT;
        else cnt_d = cnt_q + CNT_W'(1);
      end

      S_DECODE: begin
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_IMM;
        imm_src_o   = imm_dec;
        case (opcode_i)
          OP_LOAD, OP_STORE:        state_d = S_MEMADR;
          OP_OP:                    state_d = S_EXEC_R;
          OP_IMM, OP_LUI, OP_AUIPC: state_d = S_EXEC_I;
          OP_BRANCH:                state_d = S_BRANCH;
          OP_JAL:                   state_d = S_JAL;
          OP_JALR:                  state_d = S_JALR_ADR;
          default:                  state_d = S_FAULT;
        endcase
      end

      S_MEMADR: begin
        alu_src_b_o = SRC_B_IMM;
        imm_src_o   = (opcode_i == OP_STORE) ? IMM_S : IMM_I;
        off_d       = addr_lsb_i;
        if (misaligned_f(funct3_i[1:0], addr_lsb_i)) state_d = S_FAULT;
        else state_d = (opcode_i == OP_STORE) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD, S_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = (state_q == S_MEMWR);
        adr_src_o = 1'b1;
        byte_en_o = byte_en_f(funct3_i[1:0], off_q);
        if (mem_ready_i) begin
          if (state_q == S_MEMRD) state_d = S_MEMWB;
          else begin
            retired_o = 1'b1;
            state_d   = trigger ? S_FETCH : S_IDLE;
          end
        end else if (expired) state_d = S_FAULT;
        else cnt_d = cnt_q + CNT_W'(1);
      end

      S_MEMWB, S_ALUWB: begin
        reg_wr_en_o  = 1'b1;
        result_src_o = (state_q == S_MEMWB) ? RES_MEMDATA : RES_ALUOUT;
        retired_o    = 1'b1;
        state_d      = trigger ? S_FETCH : S_IDLE;
      end

      S_EXEC_R: begin
        alu_control_o = dec_op;
        state_d       = S_ALUWB;
      end

      S_EXEC_I: begin
        alu_src_b_o   = SRC_B_IMM;
        alu_control_o = dec_op;
        if (opcode_i == OP_LUI || opcode_i == OP_AUIPC) begin
          alu_src_a_o = (opcode_i == OP_LUI) ? SRC_A_ZERO : SRC_A_OLDPC;
          imm_src_o   = IMM_U;
        end
        state_d = S_ALUWB;
      end

      S_BRANCH: begin
        alu_control_o = dec_op;
        if (funct3_i[2:1] == 2'b01) state_d = S_FAULT;
        else begin
          pc_wr_en_o = taken;
          retired_o  = 1'b1;
          state_d    = trigger ? S_FETCH : S_IDLE;
        end
      end

      S_JAL, S_JALR: begin
        pc_wr_en_o  = 1'b1;
        alu_src_a_o = SRC_A_OLDPC;
        alu_src_b_o = SRC_B_FOUR;
        state_d     = S_ALUWB;
      end

      S_JALR_ADR: begin
        alu_src_b_o = SRC_B_IMM;
        state_d     = S_JALR;
      end

      S_FAULT: fault_o = 1'b1;

      default: state_d = S_FAULT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instructions through the FSM
// cycle by cycle against hand-computed control values.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger;
  logic [6:0] opcode_i;
  logic [2:0] funct3_i;
  logic       funct7_5_i;
  logic       zero_i;
  logic       alu_lsb_i;
  logic [1:0] addr_lsb_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_we_o, adr_src_o, ir_wr_en_o, pc_wr_en_o, reg_wr_en_o;
  logic [3:0] byte_en_o, alu_control_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o;
  logic [2:0] imm_src_o;
  logic       retired_o, fault_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trigger       (trigger),
    .opcode_i      (opcode_i),
    .funct3_i      (funct3_i),
    .funct7_5_i    (funct7_5_i),
    .zero_i        (zero_i),
    .alu_lsb_i     (alu_lsb_i),
    .addr_lsb_i    (addr_lsb_i),
    .mem_ready_i   (mem_ready_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .byte_en_o     (byte_en_o),
    .adr_src_o     (adr_src_o),
    .ir_wr_en_o    (ir_wr_en_o),
    .pc_wr_en_o    (pc_wr_en_o),
    .reg_wr_en_o   (reg_wr_en_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .result_src_o  (result_src_o),
    .imm_src_o     (imm_src_o),
    .alu_control_o (alu_control_o),
    .retired_o     (retired_o),
    .fault_o       (fault_o)
  );

  // Every output in one vector; fault_o is the lsb.
  wire [24:0] all_o = {mem_req_o, mem_we_o, byte_en_o, adr_src_o, ir_wr_en_o, pc_wr_en_o,
                       reg_wr_en_o, alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o,
                       alu_control_o, retired_o, fault_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] instr);
    opcode_i   = instr[6:0];
    funct3_i   = instr[14:12];
    funct7_5_i = instr[30];
  endtask

  // Entered in a FETCH cycle; leaves the bench in the following DECODE cycle.
  task automatic do_fetch(input logic [31:0] instr);
    set_instr(instr);
    mem_ready_i = 1'b1;
    #1;
    check("fetch_req", mem_req_o, 1);
    check("fetch_ir_wr", ir_wr_en_o, 1);
    check("fetch_pc_wr", pc_wr_en_o, 1);
    step();
    mem_ready_i = 1'b0;
    #1;
  endtask

  task automatic r_type(input logic [31:0] instr, input logic [3:0] exp_alu);
    do_fetch(instr);
    check("r_dec_src_a", alu_src_a_o, 2'b01);
    check("r_dec_src_b", alu_src_b_o, 2'b01);
    check("r_dec_req", mem_req_o, 0);
    step();
    check("r_exec_alu", alu_control_o, exp_alu);
    check("r_exec_srcs", {alu_src_a_o, alu_src_b_o}, 4'b0000);
    check("r_exec_regwr", reg_wr_en_o, 0);
    step();
    check("r_wb_regwr", reg_wr_en_o, 1);
    check("r_wb_retired", retired_o, 1);
    check("r_wb_result_src", result_src_o, 2'b00);
    step();
    check("r_back_fetch", mem_req_o, 1);
  endtask

  task automatic beq(input logic z, input logic exp_pc);
    do_fetch(32'h00208463);
    check("beq_dec_imm", imm_src_o, 3'b010);
    step();
    zero_i = z;
    #1;
    check("beq_alu", alu_control_o, 4'b0001);
    check("beq_pc_wr", pc_wr_en_o, exp_pc);
    check("beq_retired", retired_o, 1);
    step();
    zero_i = 1'b0;
    #1;
    check("beq_back_fetch", mem_req_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int req_cycles;
    rst_n = 1'b0; trigger = 1'b0; opcode_i = '0; funct3_i = '0; funct7_5_i = 1'b0;
    zero_i = 1'b0; alu_lsb_i = 1'b0; addr_lsb_i = '0; mem_ready_i = 1'b0;
    repeat (2) step();
    check("reset_outs", all_o, 0);
    rst_n = 1'b1;
    step();
    check("idle_outs", all_o, 0);

    trigger = 1'b1;
    step();
    check("fetch_entry_req", mem_req_o, 1);
    check("fetch_entry_adr", adr_src_o, 0);
    check("fetch_entry_srcs", {alu_src_a_o, alu_src_b_o, result_src_o}, 6'b10_10_10);

    r_type(32'h002081B3, 4'b0000);
    r_type(32'h402081B3, 4'b0001);

    // lw x3,0(x1) with ready held off three cycles in MEMRD
    do_fetch(32'h0000A183);
    check("lw_dec_imm", imm_src_o, 3'b000);
    step();
    addr_lsb_i = 2'd0;
    #1;
    check("lw_memadr_src_b", alu_src_b_o, 2'b01);
    check("lw_memadr_req", mem_req_o, 0);
    step();
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready_i = (i == 3);
      #1;
      req_cycles += int'(mem_req_o);
      check("lw_rd_byte_en", byte_en_o, 4'b1111);
      check("lw_rd_adr_src", adr_src_o, 1);
      check("lw_rd_we", mem_we_o, 0);
      step();
    end
    mem_ready_i = 1'b0;
    #1;
    check("lw_req_cycles", req_cycles, 4);
    check("lw_wb_result_src", result_src_o, 2'b01);
    check("lw_wb_regwr", reg_wr_en_o, 1);
    check("lw_wb_retired", retired_o, 1);
    check("lw_wb_req", mem_req_o, 0);
    step();

    beq(1'b1, 1'b1);
    beq(1'b0, 1'b0);

    // sb x2,0(x1) at offset 2
    do_fetch(32'h00208023);
    step();
    addr_lsb_i = 2'd2;
    #1;
    check("sb_memadr_imm", imm_src_o, 3'b001);
    step();
    mem_ready_i = 1'b1;
    #1;
    check("sb_byte_en", byte_en_o, 4'b0100);
    check("sb_we", mem_we_o, 1);
    check("sb_req", mem_req_o, 1);
    check("sb_retired", retired_o, 1);
    step();
    mem_ready_i = 1'b0;
    #1;

    // sw at offset 2 is misaligned
    do_fetch(32'h0020A023);
    step();
    addr_lsb_i = 2'd2;
    step();
    check("sw_fault_outs", all_o, 1);
    for (int i = 0; i < 6; i++) begin
      trigger = i[0];
      step();
      check("sw_fault_sticky", all_o, 1);
    end
    rst_n = 1'b0;
    #1;
    check("fault_cleared_by_reset", all_o, 0);
    step();
    rst_n = 1'b1; addr_lsb_i = 2'd0; trigger = 1'b1;

    // FETCH with ready never arriving
    step();
    check("to_first_req", mem_req_o, 1);
    for (int i = 1; i < 16; i++) begin
      step();
      check("to_wait_fault", fault_o, 0);
      check("to_wait_req", mem_req_o, 1);
    end
    step();
    check("to_fault", fault_o, 1);
    check("to_req_dropped", mem_req_o, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // reset in the middle of a MEMRD wait
    step();
    do_fetch(32'h0000A183);
    step();
    step();
    check("rst_mid_rd_req", mem_req_o, 1);
    step();
    check("rst_mid_rd_req2", mem_req_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rd_outs", all_o, 0);
    trigger = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rst_mid_rd_idle", all_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
